// File: rtl/reset_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} seq_state_t;

  // Counter width wide enough to reach the largest terminal count without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-assert / sync-deassert reset synchroniser, plus a plain data synchroniser
// used for the asynchronous PLL lock input.
module reset_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic srst
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) q <= '1;
    else      q <= {q[STAGES-2:0], 1'b0};
  end

  assign srst = q[STAGES-1];

endmodule

module data_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Cleared by the raw reset so lock is re-sampled in step with the core reset release.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: qualifies PLL lock, then drops reset domains one at a time
// (bit 0 first), re-asserting everything on lock loss or soft reset.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_RESETS       = 4,
  parameter int STAGE_CYCLES     = 4,
  parameter int LOCK_CYCLES      = 8,
  parameter int SOFT_HOLD_CYCLES = 16,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_lock,
  input  logic                  i_soft_reset,
  output logic [NUM_RESETS-1:0] o_reset,
  output logic                  o_ready
);

  localparam int CW = cnt_width(LOCK_CYCLES, STAGE_CYCLES, SOFT_HOLD_CYCLES);
  localparam int SW = $clog2(NUM_RESETS) + 1;

  logic rst_core;
  logic lock_s;

  reset_synchronizer #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk  (i_clock),
    .arst (i_reset),
    .srst (rst_core)
  );

  data_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (i_clock),
    .clr (i_reset),
    .d   (i_lock),
    .q   (lock_s)
  );

  seq_state_t            state_q, state_d;
  logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]         stage_cnt_q, stage_cnt_d;
  logic [CW-1:0]         soft_cnt_q, soft_cnt_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_RESETS-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;

  always_ff @(posedge i_clock or posedge rst_core) begin
    if (rst_core) begin
      state_q     <= HOLD;
      lock_cnt_q  <= '0;
      stage_cnt_q <= '0;
      soft_cnt_q  <= '0;
      stage_q     <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      soft_cnt_q  <= soft_cnt_d;
      stage_q     <= stage_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    stage_cnt_d = stage_cnt_q;
    soft_cnt_d  = soft_cnt_q;
    stage_d     = stage_q;
    rst_d       = rst_q;
    ready_d     = ready_q;
    case (state_q)
      HOLD: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (!lock_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d     = RELEASE;
          stage_d     = '0;
          stage_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d    = HOLD;
          lock_cnt_d = '0;
          rst_d      = '1;
          ready_d    = 1'b0;
        end else if (stage_cnt_q == CW'(STAGE_CYCLES - 1)) begin
          // Shifting a zero in from bit 0 keeps the released set contiguous.
          rst_d       = rst_q << 1;
          stage_cnt_d = '0;
          stage_d     = stage_q + SW'(1);
          if (stage_q == SW'(NUM_RESETS - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          stage_cnt_d = stage_cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = HOLD;
          lock_cnt_d = '0;
          rst_d      = '1;
          ready_d    = 1'b0;
        end else if (i_soft_reset) begin
          state_d    = SOFT;
          soft_cnt_d = '0;
          rst_d      = '1;
          ready_d    = 1'b0;
        end
      end
      SOFT: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (soft_cnt_q == CW'(SOFT_HOLD_CYCLES - 1)) begin
          state_d    = HOLD;
          lock_cnt_d = '0;
        end else begin
          soft_cnt_d = soft_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = HOLD;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign o_reset = rst_q;
  assign o_ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their edge number,
// a negedge monitor pops and compares whenever the outputs change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_lock = 1'b0;
  logic       i_soft_reset = 1'b0;
  logic [2:0] o_reset;
  logic       o_ready;

  reset_sequencer #(
    .NUM_RESETS(3), .STAGE_CYCLES(4), .LOCK_CYCLES(8),
    .SOFT_HOLD_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_lock       (i_lock),
    .i_soft_reset (i_soft_reset),
    .o_reset      (o_reset),
    .o_ready      (o_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] prev = 4'b1110;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit mono_ok(input logic [2:0] r);
    for (int j = 0; j < 2; j++)
      if (r[j] && !r[j+1]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: invariant every cycle, scoreboard on every output change.
  always @(negedge clk) begin
    logic [3:0] cur;
    exp_t e;
    cur = {o_reset, o_ready};
    checks++;
    if (!mono_ok(o_reset)) begin
      errors++;
      $display("FAIL monotone cyc=%0d o_reset=%b", cyc, o_reset);
    end
    if (cur !== prev) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_change cyc=%0d got %b", cyc, cur);
      end else begin
        e = q.pop_front();
        checks += 2;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL timing got edge %0d exp edge %0d (val %b)", cyc, e.cyc, e.val);
        end
        if (e.val !== cur) begin
          errors++;
          $display("FAIL value cyc=%0d got %b exp %b", cyc, cur, e.val);
        end
      end
      prev = cur;
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL missed_change exp edge %0d val %b, now %0d got %b", e.cyc, e.val, cyc, cur);
    end
  end

  task automatic expect_at(input int c, input logic [2:0] r, input logic rd);
    exp_t e;
    e.cyc = c;
    e.val = {r, rd};
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  // Release k of a sequence whose first lock-qualifying edge is x: x-1+8+(k+1)*4.
  task automatic expect_release(input int x);
    expect_at(x + 11, 3'b110, 1'b0);
    expect_at(x + 15, 3'b100, 1'b0);
    expect_at(x + 19, 3'b000, 1'b1);
  endtask

  int base;

  initial begin
    i_lock = 1'b1;
    #1 i_reset = 1'b1;
    tick(3);
    chk("reset_state", {o_reset, o_ready}, 4'b1110);

    // Power-up: core edge 1 is base+3; releases at edges 12/16/20.
    base = cyc;
    i_reset = 1'b0;
    expect_release(base + 3);
    tick(24);

    // Lock loss in RUN, then lock returns.
    base = cyc;
    i_lock = 1'b0;
    expect_at(base + 3, 3'b111, 1'b0);
    tick(5);
    base = cyc;
    i_lock = 1'b1;
    expect_release(base + 3);
    tick(24);

    // Soft reset in RUN: 16 held cycles, 8 qualify, then staged release.
    base = cyc;
    i_soft_reset = 1'b1;
    expect_at(base + 1, 3'b111, 1'b0);
    tick(1);
    i_soft_reset = 1'b0;
    expect_release(base + 18);
    tick(29);
    // Soft reset while o_reset = 110 must be ignored.
    i_soft_reset = 1'b1;
    tick(1);
    i_soft_reset = 1'b0;
    tick(7);

    // Async reset mid-release, between edges.
    base = cyc;
    i_soft_reset = 1'b1;
    expect_at(base + 1, 3'b111, 1'b0);
    tick(1);
    i_soft_reset = 1'b0;
    expect_at(base + 29, 3'b110, 1'b0);
    tick(29);
    chk("pre_async_release", {o_reset, o_ready}, 4'b1100);
    #1;
    expect_at(cyc, 3'b111, 1'b0);
    i_reset = 1'b1;
    #1;
    chk("async_reset_immediate", {o_reset, o_ready}, 4'b1110);
    tick(2);
    i_reset = 1'b0;
    base = cyc;

    // Lock glitch in HOLD around core edge 5: qualification restarts.
    tick(6);
    i_lock = 1'b0;
    tick(3);
    i_lock = 1'b1;
    expect_release(base + 12);
    tick(24);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
